diff_psum_row_acc_fifo: RTL and testbench

//  Consumes per-kernel-row partial sums from one PE (PE_PROCESS_WINDOW lanes per beat).

---
 rtl/diff_psum_row_acc_fifo.sv | 153 +++++++++++++++
 tb/tb_diff_psum_row_acc_fifo.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/diff_psum_row_acc_fifo.sv
// Per-PE row accumulator: sums K beats of partial sums per lane
// and queues each finished window in a small FWFT FIFO.
module diff_psum_row_acc_fifo #(
  parameter int PSUM_WIDTH = 32,
  parameter int WINDOW     = 6,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         kernel_mode,
  input  logic                         clear,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WINDOW*PSUM_WIDTH-1:0] in_psum,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WINDOW*PSUM_WIDTH-1:0] out_psum,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         overflow
);

  localparam int PW = WINDOW * PSUM_WIDTH;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // rcnt values: 0 is the idle state, the rest count accepted beats
  localparam logic [2:0] RCNT_IDLE = 3'd0;
  localparam logic [2:0] RCNT_FIRST = 3'd1;
  localparam logic [2:0] LAST_K3 = 3'd2;
  localparam logic [2:0] LAST_K5 = 3'd4;

  logic [2:0]    rcnt_q, rcnt_d;
  logic          k_lat_q, k_lat_d;
  logic [PW-1:0] acc_q, acc_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [PW-1:0] mem_q [DEPTH];

  logic [2:0]    rcnt_last;
  logic          last_beat;
  logic          full;
  logic          fire;
  logic          push;
  logic          pop;
  logic [PW-1:0] sum;
  logic          lane_ovf;

  assign rcnt_last = k_lat_q ? LAST_K5 : LAST_K3;
  assign last_beat = (rcnt_q == rcnt_last);
  assign full      = (count_q == CW'(DEPTH));

  // in_ready looks only at local state so there is no path from out_ready
  assign in_ready  = !clear && (!last_beat || !full);
  assign out_valid = (count_q != '0) && !clear;
  assign fire      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign push      = fire && last_beat;

  assign out_psum  = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign overflow  = ovf_q;

  // lane-wise wrapping add of the running sum and the incoming beat
  always_comb begin
    sum      = '0;
    lane_ovf = 1'b0;
    for (int i = 0; i < WINDOW; i++) begin
      logic [PSUM_WIDTH-1:0] a;
      logic [PSUM_WIDTH-1:0] b;
      logic [PSUM_WIDTH-1:0] s;
      a = acc_q[i*PSUM_WIDTH +: PSUM_WIDTH];
      b = in_psum[i*PSUM_WIDTH +: PSUM_WIDTH];
      s = a + b;
      sum[i*PSUM_WIDTH +: PSUM_WIDTH] = s;
      if ((a[PSUM_WIDTH-1] == b[PSUM_WIDTH-1]) &&
          (s[PSUM_WIDTH-1] != a[PSUM_WIDTH-1]))
        lane_ovf = 1'b1;
    end
  end

  // group sequencing, FIFO pointers and occupancy
  always_comb begin
    rcnt_d   = rcnt_q;
    k_lat_d  = k_lat_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      rcnt_d   = RCNT_IDLE;
      ovf_d    = 1'b0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (fire) begin
        if (rcnt_q == RCNT_IDLE) begin
          k_lat_d = kernel_mode;
          acc_d   = in_psum;
          rcnt_d  = RCNT_FIRST;
        end else begin
          acc_d  = sum;
          ovf_d  = ovf_q | lane_ovf;
          rcnt_d = last_beat ? RCNT_IDLE : rcnt_q + 3'd1;
        end
      end
      if (push)
        wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)
        rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // control and accumulator state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcnt_q   <= RCNT_IDLE;
      k_lat_q  <= 1'b0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rcnt_q   <= rcnt_d;
      k_lat_q  <= k_lat_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; the final sum is written straight from the adder
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= sum;
    end
  end

endmodule

// File: tb/tb_diff_psum_row_acc_fifo.sv
// Directed bench for diff_psum_row_acc_fifo.
// Each task drives one scenario and checks its own results.
module tb_diff_psum_row_acc_fifo;

  localparam int W  = 32;
  localparam int N  = 6;
  localparam int PW = W * N;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          kernel_mode = 1'b0;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [PW-1:0] in_psum = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [PW-1:0] out_psum;
  logic [2:0]    count;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  diff_psum_row_acc_fifo #(
    .PSUM_WIDTH(W),
    .WINDOW(N),
    .DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kernel_mode(kernel_mode),
    .clear(clear),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_psum(in_psum),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_psum(out_psum),
    .count(count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] rep(input logic [31:0] v);
    logic [PW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*W +: W] = v;
    return r;
  endfunction

  function automatic logic [PW-1:0] one_lane(input int idx,
                                             input logic [31:0] v);
    logic [PW-1:0] r;
    r = '0;
    r[idx*W +: W] = v;
    return r;
  endfunction

  function automatic logic [PW-1:0] grp_vec(input int g, input int add);
    logic [PW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*W +: W] = 32'(g * 10 + i + add);
    return r;
  endfunction

  // called at a negedge; returns at the negedge after the beat is taken
  task automatic send_beat(input logic [PW-1:0] v);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_psum  = v;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL beat_timeout in_ready=%0b required=1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_psum  = '0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || count !== 3'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state ov=%0b cnt=%0d ovf=%0b required 0 0 0",
               out_valid, count, overflow);
    end
    checks++;
    if (out_psum !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_out psum=%h rdy=%0b required 0 1",
               out_psum, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_k3();
    kernel_mode = 1'b0;
    out_ready   = 1'b1;
    send_beat(rep(32'd10));
    send_beat(rep(32'd20));
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL t1_early ov=%0b required=0", out_valid);
    end
    send_beat(rep(32'd30));
    checks++;
    if (out_valid !== 1'b1 || count !== 3'd1) begin
      errors++;
      $display("FAIL t1_valid ov=%0b cnt=%0d required 1 1",
               out_valid, count);
    end
    checks++;
    if (out_psum !== rep(32'd60)) begin
      errors++;
      $display("FAIL t1_sum got=%h required=%h", out_psum, rep(32'd60));
    end
    @(negedge clk);
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL t1_pop cnt=%0d ov=%0b required 0 0", count, out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_k5_latch();
    kernel_mode = 1'b1;
    out_ready   = 1'b0;
    send_beat(one_lane(0, 32'd5));
    send_beat(one_lane(0, -32'sd7));
    kernel_mode = 1'b0;
    send_beat(one_lane(0, 32'd100));
    checks++;
    if (count !== 3'd0) begin
      errors++;
      $display("FAIL t2_no_early_push cnt=%0d required=0", count);
    end
    send_beat(one_lane(0, -32'sd1));
    send_beat(one_lane(0, 32'd3));
    checks++;
    if (count !== 3'd1 || out_psum[31:0] !== 32'd100) begin
      errors++;
      $display("FAIL t2_sum cnt=%0d lane0=%0d required 1 100",
               count, $signed(out_psum[31:0]));
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL t2_ovf ovf=%0b required=0", overflow);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (count !== 3'd0) begin
      errors++;
      $display("FAIL t2_single_push cnt=%0d required=0", count);
    end
  endtask

  task automatic test_backpressure();
    kernel_mode = 1'b0;
    out_ready   = 1'b0;
    for (int g = 1; g <= 4; g++)
      for (int b = 0; b < 3; b++) send_beat(rep(32'(g)));
    checks++;
    if (count !== 3'd4) begin
      errors++;
      $display("FAIL t3_full cnt=%0d required=4", count);
    end
    for (int b = 0; b < 2; b++) begin
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL t3_ready_nonfinal rdy=%0b required=1", in_ready);
      end
      send_beat(rep(32'd5));
    end
    in_valid = 1'b1;
    in_psum  = rep(32'd5);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL t3_ready_final rdy=%0b required=0", in_ready);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    checks++;
    if (count !== 3'd3 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL t3_after_pop cnt=%0d rdy=%0b required 3 1",
               count, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_psum  = '0;
    checks++;
    if (count !== 3'd4) begin
      errors++;
      $display("FAIL t3_fifth cnt=%0d required=4", count);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_psum !== rep(32'(3 * (i + 2)))) begin
        errors++;
        $display("FAIL t3_order idx=%0d got=%0d required=%0d",
                 i, out_psum[31:0], 3 * (i + 2));
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    checks++;
    if (count !== 3'd0) begin
      errors++;
      $display("FAIL t3_drain cnt=%0d required=0", count);
    end
  endtask

  task automatic test_back_to_back();
    int got;
    int cyc;
    kernel_mode = 1'b0;
    out_ready   = 1'b1;
    got = 0;
    cyc = 0;
    fork
      begin
        for (int g = 0; g < 10; g++) begin
          send_beat(grp_vec(g, 0));
          send_beat(rep(32'd1));
          send_beat(rep(32'd2));
        end
      end
      begin
        while (got < 10 && cyc < 100) begin
          @(negedge clk);
          cyc++;
          checks++;
          if (count > 3'd1) begin
            errors++;
            $display("FAIL t4_count cnt=%0d required<=1", count);
          end
          if (out_valid) begin
            checks++;
            if (out_psum !== grp_vec(got, 3)) begin
              errors++;
              $display("FAIL t4_order idx=%0d got=%h required=%h",
                       got, out_psum, grp_vec(got, 3));
            end
            got++;
          end
        end
      end
    join
    checks++;
    if (got != 10) begin
      errors++;
      $display("FAIL t4_pushes got=%0d required=10", got);
    end
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (count !== 3'd0) begin
      errors++;
      $display("FAIL t4_empty cnt=%0d required=0", count);
    end
  endtask

  task automatic test_overflow();
    kernel_mode = 1'b0;
    out_ready   = 1'b0;
    send_beat(one_lane(3, 32'h7FFF_FFF0));
    send_beat(one_lane(3, 32'h0000_0020));
    send_beat(one_lane(3, 32'h0000_0000));
    checks++;
    if (out_psum[96 +: 32] !== 32'h8000_0010) begin
      errors++;
      $display("FAIL t5_wrap got=%h required=80000010", out_psum[96 +: 32]);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL t5_sticky ovf=%0b required=1", overflow);
    end
    clear = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL t5_clear_cycle ov=%0b rdy=%0b required 0 0",
               out_valid, in_ready);
    end
    @(negedge clk);
    clear = 1'b0;
    checks++;
    if (overflow !== 1'b0 || count !== 3'd0) begin
      errors++;
      $display("FAIL t5_cleared ovf=%0b cnt=%0d required 0 0",
               overflow, count);
    end
  endtask

  task automatic test_async_rst();
    kernel_mode = 1'b0;
    out_ready   = 1'b0;
    for (int b = 0; b < 3; b++) send_beat(rep(32'd7));
    kernel_mode = 1'b1;
    send_beat(rep(32'd9));
    send_beat(rep(32'd9));
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || count !== 3'd0) begin
      errors++;
      $display("FAIL t6_rst ov=%0b cnt=%0d required 0 0", out_valid, count);
    end
    rst = 1'b0;
    @(negedge clk);
    kernel_mode = 1'b1;
    for (int b = 0; b < 4; b++) send_beat(rep(32'd1));
    checks++;
    if (count !== 3'd0) begin
      errors++;
      $display("FAIL t6_partial cnt=%0d required=0", count);
    end
    send_beat(rep(32'd1));
    checks++;
    if (count !== 3'd1 || out_psum !== rep(32'd5)) begin
      errors++;
      $display("FAIL t6_fresh cnt=%0d lane0=%0d required 1 5",
               count, out_psum[31:0]);
    end
  endtask

  initial begin
    test_reset();
    test_k3();
    do_clear();
    test_k5_latch();
    do_clear();
    test_backpressure();
    do_clear();
    test_back_to_back();
    do_clear();
    test_overflow();
    do_clear();
    test_async_rst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
